regfile_sb: RTL and testbench

- Parameterised multi-read register file with an integrated write-pending scoreboard, for the pipelined RISC-V core.
- Decode allocates a destination register, marking it busy; writeback later writes the data and clears the mark.
- Read ports return register data plus a busy flag; the hazard unit stalls on busy.
- Register 0 is optionally hardwired to zero.

---
 rtl/regfile_sb.sv | 68 ++++++
 tb/tb_regfile_sb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with an integrated write-pending scoreboard.
// Ports: clk, reset (synchronous, active-high);
//   rd_addr/rd_data/rd_busy  flattened read ports, port k at [k*AW +: AW] / [k*XLEN +: XLEN] / [k];
//   wr_en/wr_addr/wr_data    writeback, clears the busy mark of the written register;
//   alloc_valid/alloc_addr/alloc_ready  destination allocation handshake, sets the busy mark;
//   busy_cnt                 registered count of busy registers.
// Define REGFILE_BYPASS_EN to forward the writeback onto every read port in the same cycle.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW = $clog2(NREG),
  parameter int NRD = 2,
  parameter bit ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              alloc_valid,
  input  logic [AW-1:0]     alloc_addr,
  output logic              alloc_ready,
  output logic [AW:0]       busy_cnt
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy, busy_nxt;
  logic wr_ok, alloc_zero, alloc_do, cnt_inc, cnt_dec;
  assign wr_ok = wr_en & ~(ZERO_REG && wr_addr == '0);
  assign alloc_zero = ZERO_REG && alloc_addr == '0;
  // A register whose producer writes back this cycle can be handed to a new producer at once.
  assign alloc_ready = alloc_zero | ~busy[alloc_addr] | (wr_ok & (wr_addr == alloc_addr));
  assign alloc_do = alloc_valid & alloc_ready & ~alloc_zero;
  // Same-address write+alloc leaves the bit set: no decrement, increment only if it was clear.
  assign cnt_inc = alloc_do & ~busy[alloc_addr];
  assign cnt_dec = wr_ok & busy[wr_addr] & ~(alloc_do & (alloc_addr == wr_addr));
  for (genvar i = 0; i < NREG; i++) begin : g_busy
    assign busy_nxt[i] = (alloc_do & (alloc_addr == AW'(i))) | (busy[i] & ~(wr_ok & (wr_addr == AW'(i))));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NREG; j++) regs[j] <= '0;
      busy <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      busy <= busy_nxt;
      busy_cnt <= busy_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] q;
    assign a = rd_addr[k*AW +: AW];
    assign q = (ZERO_REG && a == '0) ? '0 : regs[a];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wr_ok & (wr_addr == a);
    assign rd_data[k*XLEN +: XLEN] = hit ? wr_data : q;
    assign rd_busy[k] = hit ? (alloc_do & (alloc_addr == a)) : busy[a];
`else
    assign rd_data[k*XLEN +: XLEN] = q;
    assign rd_busy[k] = busy[a];
`endif
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized self-checking bench for regfile_sb against an array-based model.
module tb_regfile_sb;
  logic clk = 0;
  logic reset = 1;
  logic [9:0] rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic wr_en = 0;
  logic [4:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic alloc_valid = 0;
  logic [4:0] alloc_addr = '0;
  logic alloc_ready;
  logic [5:0] busy_cnt;
  int total = 0;
  int bad = 0;
  bit [31:0] m_reg [32];
  bit m_busy [32];

  regfile_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .alloc_ready(alloc_ready), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_wok();
    return wr_en && wr_addr != 0;
  endfunction

  function automatic bit m_ready();
    return alloc_addr == 0 || !m_busy[alloc_addr] || (m_wok() && wr_addr == alloc_addr);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (m_wok() && wr_addr == a) return wr_data;
`endif
    return a == 0 ? 32'h0 : m_reg[a];
  endfunction

  function automatic logic m_rb(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (m_wok() && wr_addr == a) return alloc_valid && m_ready() && alloc_addr == a;
`endif
    return m_busy[a];
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic void m_update();
    bit rdy;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = 0;
        m_busy[i] = 0;
      end
    end else begin
      rdy = m_ready();
      if (m_wok()) begin
        m_reg[wr_addr] = wr_data;
        m_busy[wr_addr] = 0;
      end
      if (alloc_valid && rdy && alloc_addr != 0) m_busy[alloc_addr] = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic av, input logic [4:0] aa, input logic [4:0] r0, input logic [4:0] r1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    alloc_valid = av; alloc_addr = aa;
    rd_addr = {r1, r0};
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    drive(1, 5, 32'hDEADBEEF, 1, 5, 5, 5);
    tick();
    drive(0, 0, 0, 0, 0, 5, 5);
    total++; if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b1) begin bad++; $display("FAIL preload data=%h busy=%b want DEADBEEF/1", rd_data[31:0], rd_busy[0]); end
    do_reset();
    drive(0, 0, 0, 0, 0, 5, 5);
    total++; if (rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", rd_data[31:0]); end
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b want=00", rd_busy); end
    total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", busy_cnt); end
  endtask

  task automatic test_alloc_write();
    drive(0, 0, 0, 1, 7, 7, 7);
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL alloc7_ready got=%b want=1", alloc_ready); end
    tick();
    drive(0, 0, 0, 0, 7, 7, 7);
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL alloc7_busy got=%b want=1", rd_busy[0]); end
    total++; if (busy_cnt !== 6'd1) begin bad++; $display("FAIL alloc7_cnt got=%0d want=1", busy_cnt); end
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL alloc7_reready got=%b want=0", alloc_ready); end
    drive(1, 7, 32'h12345678, 0, 0, 7, 7);
    tick();
    drive(0, 0, 0, 0, 0, 7, 7);
    total++; if (rd_data[31:0] !== 32'h12345678) begin bad++; $display("FAIL wr7_data got=%h want=12345678", rd_data[31:0]); end
    total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL wr7_busy got=%b want=0", rd_busy[0]); end
    total++; if (busy_cnt !== 6'd0) begin bad++; $display("FAIL wr7_cnt got=%0d want=0", busy_cnt); end
  endtask

  task automatic test_zero();
    int c0 = m_cnt();
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b want=1", alloc_ready); end
    total++; if (rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL zero_data_now got=%h want=0", rd_data[31:0]); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if (rd_data !== 64'h0) begin bad++; $display("FAIL zero_data got=%h want=0", rd_data); end
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL zero_busy got=%b want=00", rd_busy); end
    total++; if (busy_cnt !== 6'(c0)) begin bad++; $display("FAIL zero_cnt got=%0d want=%0d", busy_cnt, c0); end
  endtask

  task automatic test_same_cycle();
    int c0;
    drive(0, 0, 0, 1, 3, 3, 3);
    tick();
    c0 = m_cnt();
    drive(1, 3, 32'hA5, 1, 3, 3, 3);
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL same_ready got=%b want=1", alloc_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 3, 3);
    total++; if (rd_data[31:0] !== 32'hA5) begin bad++; $display("FAIL same_data got=%h want=a5", rd_data[31:0]); end
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL same_busy got=%b want=1", rd_busy[0]); end
    total++; if (busy_cnt !== 6'(c0)) begin bad++; $display("FAIL same_cnt got=%0d want=%0d", busy_cnt, c0); end
    drive(1, 3, 32'hA5, 0, 0, 3, 3);
    tick();
  endtask

  task automatic test_bypass();
    drive(1, 9, 32'h11, 0, 0, 9, 9);
    tick();
    drive(1, 9, 32'h55, 0, 0, 9, 9);
`ifdef REGFILE_BYPASS_EN
    total++; if (rd_data !== {32'h55, 32'h55} || rd_busy !== 2'b00) begin bad++; $display("FAIL byp_now got=%h/%b want 55,55/00", rd_data, rd_busy); end
`else
    total++; if (rd_data !== {32'h11, 32'h11} || rd_busy !== 2'b00) begin bad++; $display("FAIL byp_old got=%h/%b want 11,11/00", rd_data, rd_busy); end
`endif
    tick();
    drive(0, 0, 0, 0, 0, 9, 9);
    total++; if (rd_data !== {32'h55, 32'h55}) begin bad++; $display("FAIL byp_next got=%h want 55,55", rd_data); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int a = 1; a < 32; a++) begin
      drive(0, 0, 0, 1, 5'(a), 5'(a), 0);
      total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL fill_ready a=%0d got=%b want=1", a, alloc_ready); end
      tick();
      total++; if (busy_cnt !== 6'(a)) begin bad++; $display("FAIL fill_cnt a=%0d got=%0d want=%0d", a, busy_cnt, a); end
    end
    drive(0, 0, 0, 1, 4, 4, 0);
    total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL fill_realloc got=%b want=0", alloc_ready); end
    tick();
    total++; if (busy_cnt !== 6'd31 || rd_busy[0] !== 1'b1) begin bad++; $display("FAIL fill_hold cnt=%0d busy=%b want 31/1", busy_cnt, rd_busy[0]); end
    do_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      total++;
      if (rd_data[31:0] !== m_rd(rd_addr[4:0]) || rd_data[63:32] !== m_rd(rd_addr[9:5]) ||
          rd_busy !== {m_rb(rd_addr[9:5]), m_rb(rd_addr[4:0])} || alloc_ready !== m_ready() ||
          busy_cnt !== 6'(m_cnt())) begin
        bad++;
        $display("FAIL rand n=%0d got data=%h busy=%b rdy=%b cnt=%0d want data=%h%h busy=%b%b rdy=%b cnt=%0d",
                 n, rd_data, rd_busy, alloc_ready, busy_cnt, m_rd(rd_addr[9:5]), m_rd(rd_addr[4:0]),
                 m_rb(rd_addr[9:5]), m_rb(rd_addr[4:0]), m_ready(), m_cnt());
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    do_reset();
    test_reset();
    test_alloc_write();
    test_zero();
    test_same_cycle();
    test_bypass();
    test_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
